pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   Measures an incoming PWM waveform: period and high time, in clk cycles.
//   Receive-side counterpart of the team's accumulator PWM generator; used for
//   loopback checks and for reading external PWM sources (fans, servo feedback).
//   Synchronises pwm_in and emits a one-cycle valid per completed period.
//   Flags a stuck-high or stuck-low input via a timeout.
// PARAMETERS
//   N            32       width of counters and of period_out / high_out
//   SYNC_STAGES  2        input synchroniser depth (>=2)
//   TIMEOUT      1000000  cycles without an edge before stuck flag (1..2^N-1)
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  reset, asynchronous, active-low
//   pwm_in      in   1  asynchronous PWM input
//   enable      in   1  1 = measure; 0 = idle
//   period_out  out  N  last measured period (rise to rise), cycles
//   high_out    out  N  last measured high time (rise to fall), cycles
//   valid       out  1  one-cycle pulse: period_out/high_out just updated
//   stuck_high  out  1  level: input held high >= TIMEOUT cycles
//   stuck_low   out  1  level: input held low >= TIMEOUT cycles
// BEHAVIOUR
//   - Reset (async): sync chain, s_d, cnt, high_lat and all outputs = 0.
//     State = IDLE.
//   - Input path: pwm_in -> SYNC_STAGES flops -> s; s_d = s delayed 1 clk.
//     rise = s & ~s_d; fall = ~s & s_d.
//   - States: IDLE, ARM, HIGH, LOW. cnt = N-bit cycle counter.
//   - IDLE: cnt = 0, valid = 0. enable=1 -> ARM next cycle.
//   - ARM: wait for rise; cnt counts for timeout only. On rise: cnt <= 1,
//     -> HIGH. No valid is emitted for a partial first period.
//   - HIGH: cnt <= cnt+1. On fall: high_lat <= cnt, -> LOW.
//   - LOW: cnt <= cnt+1. On rise:
//       period_out <= cnt, high_out <= high_lat, valid <= 1 for one cycle.
//       stuck_high <= 0, stuck_low <= 0, cnt <= 1, -> HIGH.
//     Measurements are back-to-back with no dead cycle.
//   - Counting: a synchronised high of H cycles gives high_out = H.
//     A period of P cycles gives period_out = P.
//     Minimum measurable: high >= 1, low >= 1, so P >= 2.
//     Sub-cycle pulses may be lost.
//   - Latency: valid and outputs update on the (SYNC_STAGES)th clk edge after
//     the edge that first samples the closing rising edge of pwm_in high.
//   - Timeout: in ARM, HIGH or LOW, if cnt reaches TIMEOUT with no edge:
//       stuck_high <= s, stuck_low <= ~s; state -> ARM; cnt <= 0.
//     Flags stay set until the next valid, until enable=0, or until reset.
//     cnt never wraps: TIMEOUT <= 2^N-1.
//   - enable=0 in any state: next cycle -> IDLE, cnt = 0, valid = 0,
//     flags cleared. period_out/high_out hold their last values.
//     Re-enable restarts at ARM; the first valid needs two rises.
//   - Simultaneous enable=0 and a closing rise: enable wins, no valid.
//   - period_out/high_out change only in the cycle valid is high.
// TESTING
//   1 Reset asserted mid-run: all outputs 0 immediately, no clk needed.
//     After release the state is IDLE.
//   2 enable=1, pwm P=10 H=3 steady: first valid after the 2nd rise with
//     period_out=10, high_out=3; then valid exactly every 10 clks.
//   3 Switch to P=7 H=6: the first full new period reports 7/6.
//     The mixed transition period reports its true rise-to-rise count.
//   4 TIMEOUT=64, pwm_in held high: stuck_high=1 64 clks after the last rise,
//     no valid. Restart P=10 H=5: flag clears together with the next valid.
//   5 P=2 H=1 (fastest legal): valid every 2 clks, period_out=2, high_out=1.
//   6 enable=0 mid-HIGH: IDLE next cycle, outputs hold, no valid.
//     enable=1 again: no valid until the second rise.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an async PWM input in clk cycles.
// Emits a one-cycle valid per completed period and flags a stuck input.
module pwm_capture #(
  parameter int unsigned N           = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwm_in,
  input  logic         enable,
  output logic [N-1:0] period_out,
  output logic [N-1:0] high_out,
  output logic         valid,
  output logic         stuck_high,
  output logic         stuck_low
);

  localparam logic [N-1:0] TO  = N'(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   to_hit;

  logic [N-1:0] cnt;
  logic [N-1:0] high_lat;

  logic cnt_clr;
  logic cnt_one;
  logic cnt_inc;
  logic lat_ld;
  logic meas_ld;
  logic flag_set;
  logic flag_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign to_hit = (cnt == TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = ARM;
        ARM: begin
          if (rise) state_nxt = HIGH;
        end
        HIGH: begin
          if (fall)        state_nxt = LOW;
          else if (to_hit) state_nxt = ARM;
        end
        LOW: begin
          if (rise)        state_nxt = HIGH;
          else if (to_hit) state_nxt = ARM;
        end
      endcase
    end
  end

  // An edge in ARM restarts the timeout window so cnt never passes TIMEOUT.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_one  = 1'b0;
    cnt_inc  = 1'b0;
    lat_ld   = 1'b0;
    meas_ld  = 1'b0;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    if (!enable) begin
      cnt_clr  = 1'b1;
      flag_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: cnt_clr = 1'b1;
        ARM: begin
          if (rise || fall) begin
            cnt_one = 1'b1;
          end else if (to_hit) begin
            cnt_clr  = 1'b1;
            flag_set = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            lat_ld  = 1'b1;
            cnt_inc = 1'b1;
          end else if (to_hit) begin
            cnt_clr  = 1'b1;
            flag_set = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            meas_ld  = 1'b1;
            flag_clr = 1'b1;
            cnt_one  = 1'b1;
          end else if (to_hit) begin
            cnt_clr  = 1'b1;
            flag_set = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      high_lat   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      valid <= meas_ld;
      unique case (1'b1)
        cnt_clr: cnt <= '0;
        cnt_one: cnt <= ONE;
        cnt_inc: cnt <= cnt + ONE;
        default: cnt <= cnt;
      endcase
      if (lat_ld) high_lat <= cnt;
      if (meas_ld) begin
        period_out <= cnt;
        high_out   <= high_lat;
      end
      if (flag_clr) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (flag_set) begin
        stuck_high <= s;
        stuck_low  <= ~s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: driver pushes expected measurements per closing rise,
// monitor pops and compares them when valid fires.
module tb_pwm_capture;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic        enable;
  logic [31:0] period_out;
  logic [31:0] high_out;
  logic        valid;
  logic        stuck_high;
  logic        stuck_low;

  pwm_capture #(
    .N          (32),
    .SYNC_STAGES(2),
    .TIMEOUT    (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .enable    (enable),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low)
  );

  typedef struct {
    int p;
    int h;
    int due;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise;
  int last_h;
  bit have_prev;
  int k;

  logic [31:0] prev_p;
  logic [31:0] prev_h;
  logic        prev_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_rise();
    pwm_in = 1'b1;
    if (have_prev)
      q.push_back('{p: cyc - last_rise, h: last_h, due: cyc + LAT});
    last_rise = cyc;
    have_prev = 1'b1;
  endtask

  task automatic run(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_rise();
      tick(h);
      pwm_in = 1'b0;
      last_h = cyc - last_rise;
      tick(p - h);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("period", period_out, q[0].p);
          check("high", high_out, q[0].h);
          check("latency", cyc, q[0].due);
          check("flags_at_valid", {stuck_high, stuck_low}, 0);
          void'(q.pop_front());
        end
      end else begin
        check("hold_period", period_out, prev_p);
        check("hold_high", high_out, prev_h);
        if (q.size() > 0 && q[0].due < cyc) begin
          check("missing_valid", cyc, q[0].due);
          void'(q.pop_front());
        end
      end
    end
    prev_p   <= period_out;
    prev_h   <= high_out;
    prev_rst <= rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    pwm_in    = 1'b0;
    have_prev = 1'b0;
    last_rise = 0;
    last_h    = 0;
    tick(3);
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck_h", stuck_high, 0);
    check("rst_stuck_l", stuck_low, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_valid", valid, 0);
    enable = 1'b1;
    tick(3);

    run(10, 3, 6);
    run(7, 6, 4);

    pwm_rise();
    k = cyc;
    tick(66);
    check("stuck_early", stuck_high, 0);
    tick(1);
    check("stuck_high", stuck_high, 1);
    check("stuck_low", stuck_low, 0);
    tick(20);
    check("stuck_hold", stuck_high, 1);
    pwm_in    = 1'b0;
    have_prev = 1'b0;
    tick(5);
    run(10, 5, 1);
    check("stuck_until_valid", stuck_high, 1);
    run(10, 5, 3);
    check("stuck_cleared", stuck_high, 0);

    run(2, 1, 8);

    pwm_rise();
    tick(4);
    enable    = 1'b0;
    have_prev = 1'b0;
    tick(6);
    check("dis_period", period_out, 2);
    check("dis_high", high_out, 1);
    check("dis_valid", valid, 0);
    pwm_in = 1'b0;
    tick(4);
    enable = 1'b1;
    tick(3);
    run(6, 2, 4);

    tick(2);
    check("pre_rst_period", period_out, 6);
    check("pre_rst_queue", q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_period", period_out, 0);
    check("arst_high", high_out, 0);
    check("arst_valid", valid, 0);
    check("arst_stuck_h", stuck_high, 0);
    check("arst_stuck_l", stuck_low, 0);
    tick(2);
    rst_n = 1'b1;
    have_prev = 1'b0;
    q.delete();
    tick(3);
    check("post_rst_valid", valid, 0);
    run(10, 3, 3);
    tick(5);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
